// File: rtl/module_keypad_scan.sv
// ---------------------------------------------------------------------------
// module_keypad_scan
// Drives a 4x4 key matrix one column at a time, samples the rows and debounces
// each press/release.  The confirmed key is presented as a column index plus an
// active-low one-hot row pattern for the downstream keypad decoder.
//
// Ports
//   clk_i        in   1  system clock, rising edge
//   rst_i        in   1  asynchronous active-high reset
//   filas_i      in   4  raw row lines, active-low, asynchronous to clk_i
//   columnas_o   out  4  column drive, active-low one-hot (registered)
//   dato_codc_o  out  2  column index of the last confirmed key
//   posf_o       out  4  row pattern of the last confirmed key, 1111 = none
//   key_valid_o  out  1  one-cycle pulse per newly confirmed key
//   key_held_o   out  1  high while the confirmed key stays pressed
//
// state     | meaning
// ----------+------------------------------------------------------------
// SCAN      | column driven for SCAN_DIV cycles, sampled on the last one
// DEBOUNCE  | candidate row pattern must stay unchanged DEBOUNCE_CYC cycles
// HOLD      | key confirmed, column frozen, waiting for all rows high
// RELEASE   | rows all high, must stay so DEBOUNCE_CYC cycles to finish
// ---------------------------------------------------------------------------
module module_keypad_scan #(
    parameter int SCAN_DIV     = 27000,
    parameter int DEBOUNCE_CYC = 270000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] filas_i,
    output logic [3:0] columnas_o,
    output logic [1:0] dato_codc_o,
    output logic [3:0] posf_o,
    output logic       key_valid_o,
    output logic       key_held_o
);

    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [3:0]       r_sync1;
    logic [3:0]       r_rows_s;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_col;
    logic [3:0]       r_columnas;
    logic [3:0]       r_cand;
    logic [1:0]       r_dato;
    logic [3:0]       r_posf;
    logic             r_key_valid;

    logic             w_row_valid;
    logic             w_rows_idle;
    logic             w_tick_done;
    logic             w_stable_done;
    logic             w_col_adv;
    logic             w_cnt_clr;
    logic             w_capture;
    logic             w_confirm;
    logic             w_key_held;
    logic [1:0]       w_col_nxt;

    // A single pressed key pulls exactly one row low; anything else that is
    // not all-high means several keys share the column and is rejected.
    assign w_row_valid   = (r_rows_s == 4'b1110) || (r_rows_s == 4'b1101) ||
                           (r_rows_s == 4'b1011) || (r_rows_s == 4'b0111);
    assign w_rows_idle   = (r_rows_s == 4'b1111);
    assign w_tick_done   = (r_cnt == TICK_LAST);
    assign w_stable_done = (r_cnt == DEB_LAST);
    assign w_col_nxt     = w_col_adv ? (r_col + 2'd1) : r_col;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_SCAN;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_SCAN: begin
                if (w_tick_done && w_row_valid) w_next = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (r_rows_s != r_cand)  w_next = ST_SCAN;
                else if (w_stable_done)  w_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_rows_idle) w_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!w_rows_idle)       w_next = ST_HOLD;
                else if (w_stable_done) w_next = ST_SCAN;
            end
            default: w_next = ST_SCAN;
        endcase
    end

    // ---------------- output / control logic ----------------
    always_comb begin
        w_col_adv  = 1'b0;
        w_cnt_clr  = 1'b0;
        w_capture  = 1'b0;
        w_confirm  = 1'b0;
        w_key_held = 1'b0;
        case (r_state)
            ST_SCAN: begin
                if (w_tick_done) begin
                    w_cnt_clr = 1'b1;
                    if (w_row_valid) w_capture = 1'b1;
                    else             w_col_adv = 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (r_rows_s != r_cand) begin
                    w_col_adv = 1'b1;
                    w_cnt_clr = 1'b1;
                end else if (w_stable_done) begin
                    w_confirm = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end
            ST_HOLD: begin
                // Counter kept at zero so RELEASE always starts a fresh count.
                w_key_held = 1'b1;
                w_cnt_clr  = 1'b1;
            end
            ST_RELEASE: begin
                w_key_held = 1'b1;
                if (!w_rows_idle) begin
                    w_cnt_clr = 1'b1;
                end else if (w_stable_done) begin
                    w_col_adv = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end
            default: begin
                w_cnt_clr = 1'b1;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1     <= 4'b1111;
            r_rows_s    <= 4'b1111;
            r_cnt       <= '0;
            r_col       <= 2'd0;
            r_columnas  <= 4'b1110;
            r_cand      <= 4'b1111;
            r_dato      <= 2'd0;
            r_posf      <= 4'b1111;
            r_key_valid <= 1'b0;
        end else begin
            r_sync1  <= filas_i;
            r_rows_s <= r_sync1;

            // Saturating counter: never wraps even if a state lingers.
            if (w_cnt_clr)             r_cnt <= '0;
            else if (r_cnt != CNT_SAT) r_cnt <= r_cnt + CNT_W'(1);

            r_col      <= w_col_nxt;
            r_columnas <= ~(4'b0001 << w_col_nxt);

            if (w_capture) r_cand <= r_rows_s;

            if (w_confirm) begin
                r_dato <= r_col;
                r_posf <= r_cand;
            end
            r_key_valid <= w_confirm;
        end
    end

    assign columnas_o  = r_columnas;
    assign dato_codc_o = r_dato;
    assign posf_o      = r_posf;
    assign key_valid_o = r_key_valid;
    assign key_held_o  = w_key_held;

endmodule

// File: tb/tb_module_keypad_scan.sv
`timescale 1ns/1ps
module tb_module_keypad_scan;

    localparam int SD = 4;
    localparam int DC = 8;
    // Worst case from pin change to pulse: 2 sync + 4 column windows + debounce + 1.
    localparam int LAT_MAX = 2 + 4 * SD + DC + 1;
    localparam int LAT_MIN = 2 + 1 + DC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  filas;
    logic [3:0]  columnas;
    logic [1:0]  dato;
    logic [3:0]  posf;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = 16'h0000;   // bit r*4+c = key (row r, col c) pressed

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;

    module_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .filas_i     (filas),
        .columnas_o  (columnas),
        .dato_codc_o (dato),
        .posf_o      (posf),
        .key_valid_o (key_valid),
        .key_held_o  (key_held)
    );

    always #5 clk = ~clk;

    // Matrix model: row r is pulled low when a pressed key in that row sits on a driven column.
    always_comb begin
        filas = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !columnas[c]) filas[r] = 1'b0;
    end

    always @(negedge clk) if (!rst && key_valid) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [3:0] col_drive(input int c);
        logic [3:0] one4;
        one4 = 4'b0001;
        return ~(one4 << c);
    endfunction

    // Press (r,c), wait for confirmation, hold, then release cleanly.
    task automatic press_release(input int r, input int c, input int hold);
        int  p0, lat;
        bit  got;
        p0  = pulses;
        lat = 0;
        got = 0;
        @(negedge clk);
        keys = 16'h0001 << (r * 4 + c);
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (key_valid) got = 1;
        end
        check("press_pulse_seen", got, 1);
        check("press_latency_max", (lat <= LAT_MAX), 1);
        check("press_latency_min", (lat >= LAT_MIN), 1);
        check("press_dato", dato, c);
        check("press_posf", posf, col_drive(r));
        check("press_held", key_held, 1);
        tick(1);
        check("pulse_width", key_valid, 0);
        tick(hold);
        check("hold_columnas", columnas, col_drive(c));
        check("hold_pulses", pulses, p0 + 1);
        keys = 16'h0000;
        tick(5);
        check("release_early_held", key_held, 1);
        tick(7);
        check("release_done_held", key_held, 0);
        check("release_next_col", columnas, col_drive((c + 1) % 4));
    endtask

    initial begin
        int p0, n, run;
        bit found;
        logic [3:0] seen;

        // 1. reset and idle scanning
        #2 rst = 1'b1;
        #1;
        check("rst_columnas", columnas, 4'b1110);
        check("rst_dato", dato, 0);
        check("rst_posf", posf, 4'b1111);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            check("idle_columnas", columnas, col_drive((i / SD) % 4));
        end
        check("idle_pulses", pulses, 0);
        check("idle_posf", posf, 4'b1111);

        // 2. steady key row1/col2
        press_release(1, 2, 30);

        // 3. bouncing key row0/col1
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            keys = 16'h0001 << 1;
            tick(3);
            keys = 16'h0000;
            tick(3);
        end
        check("bounce_no_pulse", pulses, p0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (columnas == 4'b1011) found = 1;
        end
        check("bounce_scan_reaches_col2", found, 1);

        // 4. long hold with a release glitch (row3/col0)
        p0 = pulses;
        @(negedge clk);
        keys = 16'h0001 << 12;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1);
            if (key_valid) found = 1;
        end
        check("glitch_pulse_seen", found, 1);
        check("glitch_dato", dato, 0);
        check("glitch_posf", posf, 4'b0111);
        tick(100);
        keys = 16'h0000;
        tick(4);
        keys = 16'h0001 << 12;
        tick(3);
        check("glitch_held_during", key_held, 1);
        keys = 16'h0000;
        tick(5);
        check("glitch_held_early", key_held, 1);
        tick(8);
        check("glitch_held_done", key_held, 0);
        check("glitch_one_pulse", pulses, p0 + 1);
        check("glitch_next_col", columnas, col_drive(1));

        // 5. two keys in column 3 (rows 0 and 2)
        p0 = pulses;
        keys = (16'h0001 << 3) | (16'h0001 << 11);
        seen = 4'b0000;
        for (int i = 0; i < 48; i++) begin
            tick(1);
            for (int c = 0; c < 4; c++) if (columnas == col_drive(c)) seen[c] = 1'b1;
        end
        check("multi_no_pulse", pulses, p0);
        check("multi_scan_all_cols", seen, 4'b1111);
        keys = 16'h0000;
        tick(4);

        // randomized single-key presses against the press/confirm model
        for (int k = 0; k < 6; k++) begin
            press_release(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(10, 40)));
            tick(int'($urandom_range(0, 10)));
        end

        // 6. asynchronous reset while debouncing row1/col2
        p0 = pulses;
        keys = 16'h0001 << 6;
        run = 0;
        found = 0;
        n = 0;
        while (!found && n < 60) begin
            tick(1);
            n++;
            if (columnas == 4'b1011) run++;
            else run = 0;
            if (run >= SD + 1) found = 1;
        end
        check("rst6_debounce_reached", found, 1);
        #3 rst = 1'b1;
        #1;
        check("rst6_columnas", columnas, 4'b1110);
        check("rst6_dato", dato, 0);
        check("rst6_posf", posf, 4'b1111);
        check("rst6_valid", key_valid, 0);
        check("rst6_held", key_held, 0);
        keys = 16'h0000;
        tick(2);
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            check("rst6_columnas_after", columnas, col_drive((i / SD) % 4));
        end
        check("rst6_no_pulse", pulses, p0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
